// File: rtl/gamepad_port_ctrl.sv
// Polls two NES-style serial pads on a free-running schedule and serves committed button bytes to CPU port reads.
// Reads are answered combinationally every cycle; hold registers only change at the single-cycle COMMIT, so reads are never torn.
module gamepad_port_ctrl #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned POLL_INTERVAL = 1000,
  parameter logic [3:0]  PORT_GP1      = 4'd1,
  parameter logic [3:0]  PORT_GP2      = 4'd2,
  parameter logic [3:0]  PORT_STAT     = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] port_sel,
  input  logic       port_rd,
  output logic [7:0] port_data,
  output logic       port_oe,
  output logic       gp_latch,
  output logic       gp_clk,
  input  logic       gp1_data,
  input  logic       gp2_data,
  output logic       busy
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TMR_W = $clog2(POLL_INTERVAL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shadow1_q, shadow1_d;
  logic [7:0]         shadow2_q, shadow2_d;
  logic [7:0]         hold1_q, hold1_d;
  logic [7:0]         hold2_q, hold2_d;
  logic [1:0]         changed_q, changed_d;
  logic               gp_latch_q, gp_latch_d;
  logic               gp_clk_q, gp_clk_d;
  logic               phase_end;

  assign phase_end = (div_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    idx_d      = idx_q;
    shadow1_d  = shadow1_q;
    shadow2_d  = shadow2_q;
    hold1_d    = hold1_q;
    hold2_d    = hold2_q;
    changed_d  = changed_q;

    case (state_q)
      ST_IDLE: begin
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          idx_d   = 3'd0;
          div_d   = '0;
          state_d = ST_LATCH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = ST_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_LOW: begin
        if (phase_end) begin
          // Pins are active-low; store 1 = pressed.
          shadow1_d[idx_q] = ~gp1_data;
          shadow2_d[idx_q] = ~gp2_data;
          div_d            = '0;
          if (idx_q == 3'd7) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_HIGH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_end) begin
          div_d   = '0;
          state_d = ST_LOW;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        hold1_d = shadow1_q;
        hold2_d = shadow2_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Read-clear is applied first so a same-cycle COMMIT set overrides it.
    if (port_rd && (port_sel == PORT_GP1)) changed_d[0] = 1'b0;
    if (port_rd && (port_sel == PORT_GP2)) changed_d[1] = 1'b0;
    if (state_q == ST_COMMIT) begin
      if (shadow1_q != hold1_q) changed_d[0] = 1'b1;
      if (shadow2_q != hold2_q) changed_d[1] = 1'b1;
    end

    gp_latch_d = (state_d == ST_LATCH);
    gp_clk_d   = (state_d == ST_HIGH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      div_q      <= '0;
      idx_q      <= 3'd0;
      shadow1_q  <= 8'h00;
      shadow2_q  <= 8'h00;
      hold1_q    <= 8'h00;
      hold2_q    <= 8'h00;
      changed_q  <= 2'b00;
      gp_latch_q <= 1'b0;
      gp_clk_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      idx_q      <= idx_d;
      shadow1_q  <= shadow1_d;
      shadow2_q  <= shadow2_d;
      hold1_q    <= hold1_d;
      hold2_q    <= hold2_d;
      changed_q  <= changed_d;
      gp_latch_q <= gp_latch_d;
      gp_clk_q   <= gp_clk_d;
    end
  end

  assign gp_latch = gp_latch_q;
  assign gp_clk   = gp_clk_q;
  assign busy     = (state_q != ST_IDLE);

  always_comb begin
    port_oe   = 1'b0;
    port_data = 8'h00;
    if (port_rd) begin
      if (port_sel == PORT_GP1) begin
        port_oe   = 1'b1;
        port_data = hold1_q;
      end else if (port_sel == PORT_GP2) begin
        port_oe   = 1'b1;
        port_data = hold2_q;
      end else if (port_sel == PORT_STAT) begin
        port_oe   = 1'b1;
        port_data = {5'b0, busy, changed_q};
      end
    end
  end

endmodule
